// File: rtl/pampy_pkg.sv
// Shared pamPy definitions: datapath widths, loader frame header and loader FSM states.
package pampy_pkg;

  localparam int PAMPY_DATA_WIDTH        = 8;
  localparam int PAMPY_ADDR_WIDTH        = 12;
  localparam int PAMPY_INSTRUCTION_WIDTH = 16;

  localparam logic [PAMPY_DATA_WIDTH-1:0] PAMPY_HEADER = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_INSTR,
    ST_ARG,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

endpackage

// File: rtl/pampy_program_loader.sv
// Framed byte-stream loader into pamPy program memory; MEM_WE and status outputs follow the accepting edge by one cycle.
// Backpressure: IN_READY drops for the whole WRITE state, which is held while MEM_BUSY is high.
module pampy_program_loader
  import pampy_pkg::*;
#(
  parameter int GENERAL_DATA_WIDTH        = PAMPY_DATA_WIDTH,
  parameter int GENERAL_ADDR_WIDTH        = PAMPY_ADDR_WIDTH,
  parameter int GENERAL_INSTRUCTION_WIDTH = PAMPY_INSTRUCTION_WIDTH
) (
  input  logic                                 general_clk,
  input  logic                                 general_reset,
  input  logic [GENERAL_DATA_WIDTH-1:0]        IN_DATA,
  input  logic                                 IN_VALID,
  output logic                                 IN_READY,
  input  logic                                 MEM_BUSY,
  output logic                                 MEM_WE,
  output logic [GENERAL_ADDR_WIDTH-1:0]        MEM_ADDR,
  output logic [GENERAL_INSTRUCTION_WIDTH-1:0] MEM_WDATA,
  output logic                                 CORE_RESET_OUT,
  output logic                                 LOAD_DONE,
  output logic                                 LOAD_ERROR
);

  localparam int DW = GENERAL_DATA_WIDTH;
  localparam int AW = GENERAL_ADDR_WIDTH;
  localparam int CW = 2 * GENERAL_DATA_WIDTH;
  // One extra bit so a full memory's worth of words (2^AW) is representable.
  localparam logic [CW:0] MAX_WORDS = (CW + 1)'(1) << AW;

  loader_state_t state_q, state_n;

  logic [DW-1:0]                        len_hi_q;
  logic [DW-1:0]                        instr_q;
  logic [DW-1:0]                        csum_q;
  logic [CW-1:0]                        remain_q;
  logic [AW-1:0]                        addr_q;
  logic [GENERAL_INSTRUCTION_WIDTH-1:0] wdata_q;
  logic                                 core_reset_q;
  logic                                 done_q;
  logic                                 error_q;

  logic          accept;
  logic          is_header;
  logic [CW-1:0] len_word;
  logic [DW-1:0] csum_next;
  logic          len_too_big;

  assign IN_READY    = (state_q != ST_WRITE);
  assign accept      = IN_VALID && IN_READY;
  assign is_header   = (IN_DATA == PAMPY_HEADER);
  assign len_word    = {len_hi_q, IN_DATA};
  assign csum_next   = csum_q + IN_DATA;
  assign len_too_big = ({1'b0, len_word} > MAX_WORDS);

  assign MEM_WE         = (state_q == ST_WRITE);
  assign MEM_ADDR       = addr_q;
  assign MEM_WDATA      = wdata_q;
  assign CORE_RESET_OUT = core_reset_q;
  assign LOAD_DONE      = done_q;
  assign LOAD_ERROR     = error_q;

  always_ff @(posedge general_clk or posedge general_reset) begin
    if (general_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (accept && is_header) state_n = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (accept) state_n = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (accept) begin
          if (len_too_big)        state_n = ST_ERROR;
          else if (len_word == '0) state_n = ST_CSUM;
          else                    state_n = ST_INSTR;
        end
      end
      ST_INSTR: begin
        if (accept) state_n = ST_ARG;
      end
      ST_ARG: begin
        if (accept) state_n = ST_WRITE;
      end
      ST_WRITE: begin
        if (!MEM_BUSY) state_n = (remain_q == CW'(1)) ? ST_CSUM : ST_INSTR;
      end
      ST_CSUM: begin
        if (accept) state_n = (csum_next == '0) ? ST_DONE : ST_ERROR;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge general_clk or posedge general_reset) begin
    if (general_reset) begin
      len_hi_q     <= '0;
      instr_q      <= '0;
      csum_q       <= '0;
      remain_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (accept && is_header) begin
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            addr_q       <= '0;
            csum_q       <= '0;
          end
        end
        ST_LEN_HI: begin
          if (accept) begin
            len_hi_q <= IN_DATA;
            csum_q   <= csum_next;
          end
        end
        ST_LEN_LO: begin
          if (accept) begin
            remain_q <= len_word;
            csum_q   <= csum_next;
            if (len_too_big) error_q <= 1'b1;
          end
        end
        ST_INSTR: begin
          if (accept) begin
            instr_q <= IN_DATA;
            csum_q  <= csum_next;
          end
        end
        ST_ARG: begin
          if (accept) begin
            wdata_q <= {instr_q, IN_DATA};
            csum_q  <= csum_next;
          end
        end
        ST_WRITE: begin
          if (!MEM_BUSY) begin
            addr_q   <= addr_q + AW'(1);
            remain_q <= remain_q - CW'(1);
          end
        end
        ST_CSUM: begin
          if (accept) begin
            if (csum_next == '0) begin
              core_reset_q <= 1'b0;
              done_q       <= 1'b1;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
